// File: rtl/fxp_div_pkg.sv
// rtl/fxp_div_pkg.sv - shared state encoding and sizing helpers for the fixed-point divider
package fxp_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ITER  = 2'd2,
      DONE  = 2'd3
   } fxp_div_state_t;

   // One quotient bit is resolved per cycle over the extended dividend.
   function automatic int fxp_div_iters(input int width, input int frac_bits);
      return width + frac_bits;
   endfunction

   // Counter only has to hold N-1 down to 0.
   function automatic int fxp_div_cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/fxp_divider_if.sv
// rtl/fxp_divider_if.sv - controller-facing request/result bundle of the fixed-point divider
interface fxp_divider_if #(
   parameter int WIDTH = 10
);
   logic             start;
   logic [WIDTH-1:0] in_A;
   logic [WIDTH-1:0] in_B;
   logic [WIDTH-1:0] q_out;
   logic [WIDTH-1:0] r_out;
   logic             busy;
   logic             valid;
   logic             dvz;
   logic             ovf;

   modport master (
      output start, in_A, in_B,
      input  q_out, r_out, busy, valid, dvz, ovf
   );

   modport slave (
      input  start, in_A, in_B,
      output q_out, r_out, busy, valid, dvz, ovf
   );
endinterface

// File: rtl/fxp_div_datapath.sv
// rtl/fxp_div_datapath.sv - restoring divide datapath, iteration counter and result fix-up (DIV_SIGNED_EN: two's-complement operands)
module fxp_div_datapath
   import fxp_div_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter int FRAC_BITS = 4
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             load,
   input  logic             init,
   input  logic             step,
   input  logic             commit,
   input  logic             commit_dvz,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   output logic             b_zero,
   output logic             cnt_zero,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] r_out,
   output logic             dvz,
   output logic             ovf
);

   localparam int N  = fxp_div_iters(WIDTH, FRAC_BITS);
   localparam int CW = fxp_div_cnt_width(N);

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] a_mag_in;
   logic [WIDTH-1:0] b_mag_in;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] shifted_lo;
   logic [N-1:0]     quo;
   logic [N-1:0]     quo_nxt;
   logic [CW-1:0]    cnt;
   logic             ge;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic             ovf_fin;

`ifdef DIV_SIGNED_EN
   localparam logic [N-1:0] S_MAX_MAG = (N'(1) << (WIDTH-1)) - N'(1);
   localparam logic [N-1:0] S_MIN_MAG = N'(1) << (WIDTH-1);

   logic sign_a;
   logic sign_b;
   logic neg_q;

   // The core only divides magnitudes; signs are kept aside for the fix-up.
   assign a_mag_in = in_A[WIDTH-1] ? (WIDTH'(0) - in_A) : in_A;
   assign b_mag_in = in_B[WIDTH-1] ? (WIDTH'(0) - in_B) : in_B;
   assign neg_q    = sign_a ^ sign_b;

   // Range-limit the magnitude against the signed Q-format bounds, then restore signs.
   always_comb begin
      ovf_fin = quo_nxt > (neg_q ? S_MIN_MAG : S_MAX_MAG);
      if (ovf_fin) begin
         q_fin = neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         q_fin = neg_q ? (WIDTH'(0) - quo_nxt[WIDTH-1:0]) : quo_nxt[WIDTH-1:0];
      end
      r_fin = sign_a ? (WIDTH'(0) - rem_nxt) : rem_nxt;
   end
`else
   localparam logic [N-1:0] U_MAX = (N'(1) << WIDTH) - N'(1);

   assign a_mag_in = in_A;
   assign b_mag_in = in_B;

   // Any set bit above the WIDTH-bit window means the quotient does not fit.
   always_comb begin
      ovf_fin = quo_nxt > U_MAX;
      q_fin   = ovf_fin ? {WIDTH{1'b1}} : quo_nxt[WIDTH-1:0];
      r_fin   = rem_nxt;
   end
`endif

   assign b_zero   = (b_mag == '0);
   assign cnt_zero = (cnt == '0);

   // One restoring step: shift the next dividend bit in, keep the difference when it fits.
   // rem < b_mag always, so its top bit set already guarantees the shifted value exceeds b_mag
   // and a WIDTH-bit wrapping subtraction still yields the correct remainder.
   always_comb begin
      shifted_lo = {rem[WIDTH-2:0], quo[N-1]};
      ge         = rem[WIDTH-1] || (shifted_lo >= b_mag);
      rem_nxt    = ge ? (shifted_lo - b_mag) : shifted_lo;
      quo_nxt    = {quo[N-2:0], ge};
   end

   // Operand capture, iteration state and counter.
   always_ff @(posedge clk) begin
      if (sclr) begin
         a_mag <= '0;
         b_mag <= '0;
         rem   <= '0;
         quo   <= '0;
         cnt   <= '0;
`ifdef DIV_SIGNED_EN
         sign_a <= 1'b0;
         sign_b <= 1'b0;
`endif
      end else begin
         if (load) begin
            a_mag <= a_mag_in;
            b_mag <= b_mag_in;
`ifdef DIV_SIGNED_EN
            sign_a <= in_A[WIDTH-1];
            sign_b <= in_B[WIDTH-1];
`endif
         end
         if (init) begin
            rem <= '0;
            quo <= N'(a_mag) << FRAC_BITS;
            cnt <= CW'(N-1);
         end
         if (step) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (!cnt_zero) begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

   // Result registers change only on entry to DONE and hold until the next one.
   always_ff @(posedge clk) begin
      if (sclr) begin
         q_out <= '0;
         r_out <= '0;
         dvz   <= 1'b0;
         ovf   <= 1'b0;
      end else if (commit_dvz) begin
         q_out <= '0;
         r_out <= '0;
         dvz   <= 1'b1;
         ovf   <= 1'b0;
      end else if (commit) begin
         q_out <= q_fin;
         r_out <= r_fin;
         dvz   <= 1'b0;
         ovf   <= ovf_fin;
      end
   end

endmodule

// File: rtl/fxp_divider.sv
// rtl/fxp_divider.sv - sequential fixed-point restoring divider top with control FSM (DIV_SIGNED_EN: signed build)
module fxp_divider
   import fxp_div_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter int FRAC_BITS = 4
) (
   input  logic        clk,
   input  logic        sclr,
   fxp_divider_if.slave bus
);

   fxp_div_state_t state;
   fxp_div_state_t state_nxt;

   logic accept;
   logic init;
   logic step;
   logic commit;
   logic commit_dvz;
   logic b_zero;
   logic cnt_zero;

   // State register.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; start is only looked at in IDLE and DONE, so it is ignored while busy.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = bus.start ? CHECK : IDLE;
         CHECK:   state_nxt = b_zero ? DONE : ITER;
         ITER:    state_nxt = cnt_zero ? DONE : ITER;
         DONE:    state_nxt = bus.start ? CHECK : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath strobes and status outputs decoded from the current state.
   always_comb begin
      accept     = bus.start && ((state == IDLE) || (state == DONE));
      init       = (state == CHECK) && !b_zero;
      commit_dvz = (state == CHECK) && b_zero;
      step       = (state == ITER);
      commit     = (state == ITER) && cnt_zero;
      bus.busy   = (state == CHECK) || (state == ITER);
      bus.valid  = (state == DONE);
   end

   fxp_div_datapath #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_datapath (
      .clk        (clk),
      .sclr       (sclr),
      .load       (accept),
      .init       (init),
      .step       (step),
      .commit     (commit),
      .commit_dvz (commit_dvz),
      .in_A       (bus.in_A),
      .in_B       (bus.in_B),
      .b_zero     (b_zero),
      .cnt_zero   (cnt_zero),
      .q_out      (bus.q_out),
      .r_out      (bus.r_out),
      .dvz        (bus.dvz),
      .ovf        (bus.ovf)
   );

endmodule

// File: tb/tb_fxp_divider.sv
// tb/tb_fxp_divider.sv - randomized self-checking bench for fxp_divider against an arithmetic reference
module tb_fxp_divider;

   localparam int W = 10;
   localparam int F = 4;
   localparam int N = W + F;

   logic clk = 1'b0;
   logic sclr;

   always #5 clk = ~clk;

   fxp_divider_if #(.WIDTH(W)) bus ();

   fxp_divider #(
      .WIDTH     (W),
      .FRAC_BITS (F)
   ) dut (
      .clk  (clk),
      .sclr (sclr),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer division of A*2^F by B, then range handling.
   task automatic ref_div(input longint a, input longint b,
                          output longint q, output longint r,
                          output logic dvz, output logic ovf);
      longint full;
      longint half;
      longint ma;
      longint mb;
      longint rq;
      longint rr;
      logic   sa;
      logic   sb;
      full = longint'(1) << W;
      half = full >> 1;
      q = 0; r = 0; dvz = 1'b0; ovf = 1'b0;
      if (b == 0) begin
         dvz = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = (a >= half);
         sb = (b >= half);
         ma = sa ? full - a : a;
         mb = sb ? full - b : b;
         rq = (ma * (longint'(1) << F)) / mb;
         rr = (ma * (longint'(1) << F)) % mb;
         if (sa != sb) begin
            ovf = (rq > half);
            q   = ovf ? half : (full - rq) % full;
         end else begin
            ovf = (rq > half - 1);
            q   = ovf ? half - 1 : rq;
         end
         r = sa ? (full - rr) % full : rr;
`else
         sa = 1'b0; sb = 1'b0; ma = a; mb = b;
         rq = (ma * (longint'(1) << F)) / mb;
         rr = (ma * (longint'(1) << F)) % mb;
         ovf = (rq > full - 1);
         q   = ovf ? full - 1 : rq;
         r   = rr;
`endif
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      longint q;
      longint r;
      logic   dvz;
      logic   ovf;
      ref_div(longint'(a), longint'(b), q, r, dvz, ovf);
      check_eq({tag, "/q"},   bus.q_out, q);
      check_eq({tag, "/r"},   bus.r_out, r);
      check_eq({tag, "/dvz"}, bus.dvz,   dvz);
      check_eq({tag, "/ovf"}, bus.ovf,   ovf);
   endtask

   // Counts edges since the accepting edge until valid is seen at a falling edge.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (bus.valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_A  = a;
      bus.in_B  = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_A  = W'($urandom);
      bus.in_B  = W'($urandom);
      check_eq({tag, "/busy_on"}, bus.busy, 1'b1);
      wait_valid(lat);
      check_eq({tag, "/latency"}, lat, (b == '0) ? 2 : N + 2);
      check_eq({tag, "/busy_off"}, bus.busy, 1'b0);
      check_result(tag, a, b);
      @(negedge clk);
      check_eq({tag, "/valid_pulse"}, bus.valid, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int vcount;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int sel;

      bus.start = 1'b0;
      bus.in_A  = '0;
      bus.in_B  = '0;
      sclr      = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst/q",     bus.q_out, 0);
      check_eq("rst/r",     bus.r_out, 0);
      check_eq("rst/busy",  bus.busy,  0);
      check_eq("rst/valid", bus.valid, 0);
      check_eq("rst/dvz",   bus.dvz,   0);
      check_eq("rst/ovf",   bus.ovf,   0);
      sclr = 1'b0;

      do_div(W'(100), W'(7), "d100_7");
      check_eq("d100_7/q_const", bus.q_out, 228);
      check_eq("d100_7/r_const", bus.r_out, 4);
`ifdef DIV_SIGNED_EN
      do_div(W'(10'h39C), W'(7), "dneg100_7");
      check_eq("dneg100_7/q_const", bus.q_out, 10'h31C);
      check_eq("dneg100_7/r_const", bus.r_out, 10'h3FC);
      check_eq("dneg100_7/ovf_const", bus.ovf, 0);
`else
      do_div(W'(1000), W'(1), "d1000_1");
      check_eq("d1000_1/q_const", bus.q_out, 10'h3FF);
      check_eq("d1000_1/ovf_const", bus.ovf, 1);
`endif
      do_div(W'(55), W'(0), "dvz55");
      check_eq("dvz55/dvz_const", bus.dvz, 1);
      check_eq("dvz55/q_const", bus.q_out, 0);

      // start held through the whole operation, new operands offered while busy
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_A  = W'(100);
      bus.in_B  = W'(7);
      @(negedge clk);
      bus.in_A  = W'(10);
      bus.in_B  = W'(3);
      wait_valid(lat);
      check_eq("hold1/latency", lat, N + 2);
      check_result("hold1", W'(100), W'(7));
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("hold2/busy_on", bus.busy, 1);
      check_eq("hold2/no_valid", bus.valid, 0);
      wait_valid(lat);
      check_eq("hold2/latency", lat, N + 2);
      check_eq("hold2/q_const", bus.q_out, 53);
      check_eq("hold2/r_const", bus.r_out, 1);
      check_result("hold2", W'(10), W'(3));

      // abort mid-iteration
      @(negedge clk);
      bus.start = 1'b1;
      bus.in_A  = W'(100);
      bus.in_B  = W'(7);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
      check_eq("abort/q",     bus.q_out, 0);
      check_eq("abort/r",     bus.r_out, 0);
      check_eq("abort/busy",  bus.busy,  0);
      check_eq("abort/valid", bus.valid, 0);
      check_eq("abort/dvz",   bus.dvz,   0);
      check_eq("abort/ovf",   bus.ovf,   0);
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.valid === 1'b1 || bus.busy === 1'b1) vcount++;
      end
      check_eq("abort/idle_after", vcount, 0);

      for (int i = 0; i < 40; i++) begin
         a   = W'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0)      b = '0;
         else if (sel < 4)  b = W'($urandom_range(1, 15));
         else               b = W'($urandom);
         do_div(a, b, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fxp_divider.md
# fxp_divider

Parametrised sequential restoring divider that succeeds the fixed 10-bit CA1 divider. It divides a WIDTH-bit dividend by a WIDTH-bit divisor and returns a fixed-point quotient with FRAC_BITS fractional bits, plus the remainder. It resolves one quotient bit per cycle and signals start/busy/valid, with divide-by-zero and overflow flags. It sits as a multi-cycle arithmetic unit beside the datapath and is driven by a controller through a start pulse.

## Interface
- WIDTH, 10: operand, quotient and remainder width in bits (>= 4).
- FRAC_BITS, 4: fractional quotient bits, 0 .. WIDTH-1. N = WIDTH + FRAC_BITS is the iteration count.
- clk  in  1  clock; all state changes on the rising edge.
- sclr  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- in_A  in  WIDTH  dividend, integer. Captured on the accepting edge.
- in_B  in  WIDTH  divisor, integer. Captured on the accepting edge.
- q_out  out  WIDTH  quotient, format (WIDTH-FRAC_BITS).FRAC_BITS.
- r_out  out  WIDTH  remainder of (A << FRAC_BITS) / B.
- busy  out  1  high in CHECK and ITER.
- valid  out  1  one-cycle pulse in DONE.
- dvz  out  1  divide-by-zero flag for the last result.
- ovf  out  1  overflow flag for the last result.

## Operation
- States:
  - IDLE: start=1 captures A and B, goes to CHECK.
  - CHECK: B==0 sets dvz=1 and goes to DONE. Otherwise it clears the partial remainder, loads counter = N-1 and goes to ITER.
  - ITER: each cycle shifts {rem, dividend_ext} left by 1, then trial-subtracts B. If the result is non-negative, it keeps the difference and shifts in 1; otherwise it shifts in 0. At counter==0 it goes to DONE; otherwise it decrements.
  - DONE: valid=1 and results are written. start=1 goes to CHECK (back-to-back); otherwise the block returns to IDLE.
- The extended dividend is A followed by FRAC_BITS zeros. The raw quotient is N bits wide.
- Unsigned overflow: ovf=1 when the top FRAC_BITS bits of the raw quotient are nonzero. q_out then saturates to all ones.
- On dvz: q_out=0, r_out=0, ovf=0.
- q_out, r_out, dvz and ovf update only on entry to DONE. They hold until the next DONE.
- start while busy is ignored. There is no queueing.
- Reset values: state IDLE; q_out, r_out, busy, valid, dvz and ovf are all 0. sclr mid-operation aborts the operation with no valid pulse.

## Timing
- Start accepted at edge k: CHECK during cycle k+1, ITER during k+2 .. k+N+1, DONE/valid during k+N+2.
- Latency from start to valid is N+2 cycles. On dvz it is 2 cycles.
- Back-to-back throughput is one result per N+2 cycles. In the back-to-back case, valid and the next CHECK are not simultaneous: DONE precedes CHECK.
- busy falls in the same cycle valid rises.

## Configuration
- DIV_SIGNED_EN defined: in_A, in_B, q_out and r_out are two's complement.
  - Magnitudes are divided.
  - The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - ovf=1 when the signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] in Q format. q_out then saturates to the max or min matching the result sign.
  - Latency is unchanged. Sign fix-up is combinational on DONE entry.
- Undefined: the block is unsigned only, with no sign logic synthesised.

## Structure
- Package fxp_div_pkg holds:
  - the state enum (IDLE, CHECK, ITER, DONE);
  - a function for N;
  - a counter width function, clog2(N).
- One sub-module, fxp_div_datapath, holds the remainder/quotient shift registers, the subtractor, the counter, and the saturation/sign fix-up. The FSM stays in the top module.

## Test plan
- WIDTH=10, FRAC=4, A=100, B=7 -> valid at start+16, q_out=228 (14.25), r_out=4, ovf=0, dvz=0.
- A=1000, B=1 -> ovf=1, q_out=0x3FF, valid at start+16.
- B=0, A=55 -> dvz=1, q_out=0, r_out=0, valid at start+2.
- start held during busy, then asserted in DONE with A=10, B=3 -> second request ignored while busy. The DONE start is accepted: q_out=53, r_out=1.
- sclr asserted during ITER -> next cycle all outputs are 0 and state is IDLE; no valid pulse follows.
- DIV_SIGNED_EN, A=-100 (0x39C), B=7 -> q_out=0x31C (-228), r_out=0x3FC (-4), ovf=0.
